// File: rtl/accel_pkg.sv
// ---------------------------------------------------------------------------
// accel_pkg
// Shared constants, state encoding and small helpers for the accelerometer
// decimation/trim datapath.
//   DATA_WIDTH    : raw and filtered sample width (signed two's complement)
//   MAX_DEC_LOG2  : largest decimation exponent (window of up to 128 samples)
//   ACC_WIDTH     : accumulator width, sized so 2^MAX_DEC_LOG2 full-scale
//                   samples can never overflow
//   SAT_MAX/MIN   : saturation bounds of a DATA_WIDTH signed result
// ---------------------------------------------------------------------------
package accel_pkg;

   localparam int DATA_WIDTH   = 20;
   localparam int MAX_DEC_LOG2 = 7;
   localparam int ACC_WIDTH    = DATA_WIDTH + MAX_DEC_LOG2;
   localparam int SEL_WIDTH    = 3;

   localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_e;

   // Limit a requested decimation exponent to what the accumulator supports.
   function automatic logic [SEL_WIDTH-1:0] clip_sel(input logic [SEL_WIDTH-1:0] sel);
      if (int'(sel) > MAX_DEC_LOG2) begin
         return SEL_WIDTH'(MAX_DEC_LOG2);
      end
      return sel;
   endfunction

   // Sample index (0-based) of the last sample in a window of 2^sel samples.
   function automatic logic [MAX_DEC_LOG2-1:0] win_last(input logic [SEL_WIDTH-1:0] sel);
      logic [MAX_DEC_LOG2:0] n;
      n = (MAX_DEC_LOG2+1)'(1) << sel;
      return MAX_DEC_LOG2'(n - (MAX_DEC_LOG2+1)'(1));
   endfunction

endpackage

// File: rtl/accel_sat_sub.sv
// ---------------------------------------------------------------------------
// accel_sat_sub
// Combinational saturating subtract: y = sat(a - b) into DATA_WIDTH bits.
//   a     : DATA_WIDTH+1 signed minuend
//   b     : DATA_WIDTH signed subtrahend
//   y     : DATA_WIDTH signed result, clamped to [SAT_MIN, SAT_MAX]
//   clamp : high when the true difference fell outside that range
// ---------------------------------------------------------------------------
module accel_sat_sub
   import accel_pkg::*;
(
   input  logic signed [DATA_WIDTH:0]   a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [DATA_WIDTH-1:0] y,
   output logic                         clamp
);

   // Two extra bits hold any (DATA_WIDTH+1) - DATA_WIDTH difference exactly.
   localparam logic signed [DATA_WIDTH+1:0] HI = (DATA_WIDTH+2)'(SAT_MAX);
   localparam logic signed [DATA_WIDTH+1:0] LO = (DATA_WIDTH+2)'(SAT_MIN);

   logic signed [DATA_WIDTH+1:0] diff;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the if/else can leave a value unassigned and infer a latch.
   always_comb begin
      diff  = (DATA_WIDTH+2)'(a) - (DATA_WIDTH+2)'(b);
      y     = diff[DATA_WIDTH-1:0];
      clamp = 1'b0;
      if (diff > HI) begin
         y     = SAT_MAX;
         clamp = 1'b1;
      end else if (diff < LO) begin
         y     = SAT_MIN;
         clamp = 1'b1;
      end
   end

endmodule

// File: rtl/accel_decim_filter.sv
// ---------------------------------------------------------------------------
// accel_decim_filter
// Decimating boxcar averager with offset trim for one ADXL355 axis. Sums
// 2^odr_sel samples, divides by arithmetic shift, subtracts offset with
// saturation and emits one FIFO write per window.
//   clk, rst_n        : clock, asynchronous active-low reset
//   adc_data          : signed raw sample, qualified by adc_valid
//   adc_valid         : one-cycle sample strobe
//   filter_en         : enable; dropping it discards the partial window
//   odr_sel           : decimation exponent, sampled at each window start
//   offset            : signed offset subtracted from the average
//   filter_fifo_data  : averaged sample, held until the next write
//   wr_en             : one-cycle FIFO write strobe
//   overrange         : high with wr_en when the result was clamped
// Pipeline: window-end edge -> sum_q; next edge -> avg_q; next edge ->
// outputs, so wr_en rises two edges after the final adc_valid is sampled.
// ---------------------------------------------------------------------------
module accel_decim_filter
   import accel_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [DATA_WIDTH-1:0] adc_data,
   input  logic                         adc_valid,
   input  logic                         filter_en,
   input  logic [SEL_WIDTH-1:0]         odr_sel,
   input  logic signed [DATA_WIDTH-1:0] offset,
   output logic signed [DATA_WIDTH-1:0] filter_fifo_data,
   output logic                         wr_en,
   output logic                         overrange
);

   state_e                        state_q, state_d;
   logic signed [ACC_WIDTH-1:0]   acc_q;
   logic [MAX_DEC_LOG2-1:0]       cnt_q;
   logic [SEL_WIDTH-1:0]          sel_q;
   logic signed [ACC_WIDTH-1:0]   sum_q;
   logic [SEL_WIDTH-1:0]          sum_sh_q;
   logic                          pend_q;
   logic signed [DATA_WIDTH:0]    avg_q;
   logic                          avg_vld_q;

   logic signed [ACC_WIDTH-1:0]   sample_ext;
   logic signed [ACC_WIDTH-1:0]   acc_sum;
   logic                          accept;
   logic                          win_end;
   logic signed [DATA_WIDTH-1:0]  res;
   logic                          res_clamp;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (filter_en)  state_d = ACCUM;
         ACCUM:   if (!filter_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- Accumulation ----------------
   assign sample_ext = ACC_WIDTH'(adc_data);
   assign acc_sum    = acc_q + sample_ext;
   assign accept     = (state_q == ACCUM) && filter_en && adc_valid;
   assign win_end    = accept && (cnt_q == win_last(sel_q));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours regardless of code order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         sel_q <= '0;
      end else if (state_q == IDLE) begin
         acc_q <= '0;
         cnt_q <= '0;
         if (filter_en) begin
            sel_q <= clip_sel(odr_sel);
         end
      end else if (!filter_en) begin
         // Leaving ACCUM: the partial window is thrown away.
         acc_q <= '0;
         cnt_q <= '0;
      end else if (win_end) begin
         // Window size for the next window is taken here, so odr_sel changes
         // mid-window never alter the window in progress.
         acc_q <= '0;
         cnt_q <= '0;
         sel_q <= clip_sel(odr_sel);
      end else if (accept) begin
         acc_q <= acc_sum;
         cnt_q <= cnt_q + MAX_DEC_LOG2'(1);
      end
   end

   // ---------------- Output pipeline ----------------
   // sum_sh_q keeps the finished window's exponent because sel_q has already
   // moved on to the next window by the time the average is formed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q     <= '0;
         sum_sh_q  <= '0;
         pend_q    <= 1'b0;
         avg_q     <= '0;
         avg_vld_q <= 1'b0;
      end else begin
         pend_q    <= win_end;
         avg_vld_q <= pend_q;
         if (win_end) begin
            sum_q    <= acc_sum;
            sum_sh_q <= sel_q;
         end
         if (pend_q) begin
            // The mean of in-range samples always fits DATA_WIDTH bits, so
            // truncating the shifted sum loses nothing.
            avg_q <= (DATA_WIDTH+1)'(sum_q >>> sum_sh_q);
         end
      end
   end

   accel_sat_sub u_sat_sub (
      .a     (avg_q),
      .b     (offset),
      .y     (res),
      .clamp (res_clamp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filter_fifo_data <= '0;
         wr_en            <= 1'b0;
         overrange        <= 1'b0;
      end else begin
         wr_en     <= avg_vld_q;
         overrange <= avg_vld_q && res_clamp;
         if (avg_vld_q) begin
            filter_fifo_data <= res;
         end
      end
   end

endmodule

// File: tb/tb_accel_decim_filter.sv
// ---------------------------------------------------------------------------
// tb_accel_decim_filter
// Self-checking bench: a window/average model built on queues and integer
// division predicts every FIFO write (value, overrange, cycle); a monitor
// compares each cycle, and scenario tasks compare directed results.
// ---------------------------------------------------------------------------
module tb_accel_decim_filter;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [19:0] adc_data = '0;
   logic               adc_valid = 1'b0;
   logic               filter_en = 1'b0;
   logic [2:0]         odr_sel = '0;
   logic signed [19:0] offset = '0;
   logic signed [19:0] filter_fifo_data;
   logic               wr_en;
   logic               overrange;

   accel_decim_filter dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .adc_data         (adc_data),
      .adc_valid        (adc_valid),
      .filter_en        (filter_en),
      .odr_sel          (odr_sel),
      .offset           (offset),
      .filter_fifo_data (filter_fifo_data),
      .wr_en            (wr_en),
      .overrange        (overrange)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] data;
      logic        over;
      int          cyc;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   exp_t        exp_q[$];
   logic [19:0] obs_q[$];
   logic        obs_ov[$];
   logic [19:0] hold_exp = '0;

   // Reference model state: whether the filter is collecting, the current
   // window length and the samples collected so far.
   bit          m_active = 1'b0;
   int          m_n = 1;
   longint      m_win[$];

   function automatic int win_len(input logic [2:0] sel);
      return 1 << ((sel > 3'd7) ? 7 : int'(sel));
   endfunction

   // Expected result for a finished window: floor mean, minus offset, clamp.
   function automatic exp_t predict(input longint sum, input int n, input int off, input int c);
      exp_t   e;
      longint q, r;
      q = sum / n;
      if ((sum % n) != 0 && sum < 0) q = q - 1;
      r = q - off;
      e.over = 1'b0;
      if (r > 524287) begin
         r = 524287;  e.over = 1'b1;
      end else if (r < -524288) begin
         r = -524288; e.over = 1'b1;
      end
      e.data = r[19:0];
      e.cyc  = c;
      return e;
   endfunction

   // Applies the inputs about to be sampled at the next edge to the model.
   task automatic model_edge();
      longint s;
      if (!m_active) begin
         if (filter_en) begin
            m_active = 1'b1;
            m_n = win_len(odr_sel);
            m_win.delete();
         end
      end else if (!filter_en) begin
         m_active = 1'b0;
         m_win.delete();
      end else if (adc_valid) begin
         m_win.push_back(longint'(adc_data));
         if (m_win.size() == m_n) begin
            s = 0;
            foreach (m_win[i]) s += m_win[i];
            // Sampled at edge cyc+1, visible after edge cyc+3.
            exp_q.push_back(predict(s, m_n, int'(offset), cyc + 3));
            m_win.delete();
            m_n = win_len(odr_sel);
         end
      end
   endtask

   // One clock: present inputs, update model, advance to 2 time units past
   // the next edge.
   task automatic step(input logic v, input logic signed [19:0] d);
      adc_valid = v;
      adc_data  = d;
      model_edge();
      @(posedge clk);
      #2;
      adc_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   task automatic drain();
      idle(5);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Restart the filter with a fresh window length and offset.
   task automatic restart(input logic [2:0] sel, input logic signed [19:0] off);
      filter_en = 1'b0;
      step(1'b0, '0);
      odr_sel   = sel;
      offset    = off;
      filter_en = 1'b1;
      step(1'b0, '0);
   endtask

   // Per-cycle monitor, sampling 1 time unit after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (wr_en === 1'b1) begin
            obs_q.push_back(filter_fifo_data);
            obs_ov.push_back(overrange);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_wr_en cyc=%0d data=%h", cyc, filter_fifo_data);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (cyc != e.cyc) begin
                  errors++;
                  $display("FAIL latency cyc=%0d required=%0d", cyc, e.cyc);
               end
               checks++;
               if (filter_fifo_data !== e.data || overrange !== e.over) begin
                  errors++;
                  $display("FAIL output data=%h ov=%b required data=%h ov=%b",
                           filter_fifo_data, overrange, e.data, e.over);
               end
               hold_exp = e.data;
            end
         end else begin
            checks++;
            if (wr_en !== 1'b0 || overrange !== 1'b0 || filter_fifo_data !== hold_exp) begin
               errors++;
               $display("FAIL hold cyc=%0d wr_en=%b ov=%b data=%h required 0 0 %h",
                        cyc, wr_en, overrange, filter_fifo_data, hold_exp);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               errors++;
               $display("FAIL missing_wr_en cyc=%0d required_at=%0d", cyc, exp_q[0].cyc);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic check_count(input string name, input int base, input int want);
      checks++;
      if (obs_q.size() - base != want) begin
         errors++;
         $display("FAIL %s_count got=%0d required=%0d", name, obs_q.size() - base, want);
      end
   endtask

   task automatic check_val(input string name, input int idx, input logic [19:0] d, input logic ov);
      checks++;
      if (idx >= obs_q.size()) begin
         errors++;
         $display("FAIL %s missing output index %0d", name, idx);
      end else if (obs_q[idx] !== d || obs_ov[idx] !== ov) begin
         errors++;
         $display("FAIL %s got=%h ov=%b required=%h ov=%b", name, obs_q[idx], obs_ov[idx], d, ov);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (wr_en !== 1'b0 || overrange !== 1'b0 || filter_fifo_data !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs wr_en=%b ov=%b data=%h required 0 0 0",
                  wr_en, overrange, filter_fifo_data);
      end
      exp_q.delete();
      m_win.delete();
      m_active = 1'b0;
      hold_exp = '0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      apply_reset();
      idle(3);
   endtask

   task automatic test_basic();
      int base = obs_q.size();
      restart(3'd2, 20'sd0);
      step(1'b1, 20'sd100); step(1'b0, '0);
      step(1'b1, 20'sd200); step(1'b0, '0);
      step(1'b1, 20'sd300);
      step(1'b1, 20'sd400);
      drain();
      check_count("basic", base, 1);
      check_val("basic_250", base, 20'd250, 1'b0);
   endtask

   task automatic test_negative();
      int base = obs_q.size();
      restart(3'd1, 20'sd0);
      step(1'b1, -20'sd3); step(1'b1, -20'sd4);
      drain();
      restart(3'd1, 20'sd5);
      step(1'b1, -20'sd3); step(1'b1, -20'sd4);
      drain();
      check_count("negative", base, 2);
      check_val("neg_floor", base, 20'hFFFFC, 1'b0);
      check_val("neg_offset", base + 1, 20'hFFFF7, 1'b0);
   endtask

   task automatic test_saturation();
      int base = obs_q.size();
      restart(3'd0, -20'sd10);
      step(1'b1, 20'sd524280);
      drain();
      restart(3'd0, 20'sd1);
      step(1'b1, -20'sd524288);
      drain();
      check_count("sat", base, 2);
      check_val("sat_max", base, 20'h7FFFF, 1'b1);
      check_val("sat_min", base + 1, 20'h80000, 1'b1);
   endtask

   task automatic test_back_to_back();
      int base = obs_q.size();
      restart(3'd2, 20'sd0);
      for (int i = 1; i <= 12; i++) step(1'b1, 20'(i));
      drain();
      check_count("b2b", base, 3);
      check_val("b2b_0", base, 20'd2, 1'b0);
      check_val("b2b_1", base + 1, 20'd6, 1'b0);
      check_val("b2b_2", base + 2, 20'd10, 1'b0);
   endtask

   task automatic test_odr_change();
      int base = obs_q.size();
      restart(3'd2, 20'sd0);
      step(1'b1, 20'sd10); step(1'b1, 20'sd20);
      odr_sel = 3'd3;
      step(1'b1, 20'sd30); step(1'b1, 20'sd40);
      for (int i = 1; i <= 8; i++) step(1'b1, 20'(i));
      drain();
      check_count("odr", base, 2);
      check_val("odr_win4", base, 20'd25, 1'b0);
      check_val("odr_win8", base + 1, 20'd4, 1'b0);
      base = obs_q.size();
      restart(3'd7, 20'sd0);
      for (int i = 0; i < 128; i++) step(1'b1, 20'sd524287);
      drain();
      check_count("odr7", base, 1);
      check_val("odr7_full", base, 20'h7FFFF, 1'b0);
   endtask

   task automatic test_filter_en_drop();
      int base = obs_q.size();
      restart(3'd2, 20'sd0);
      for (int i = 0; i < 3; i++) step(1'b1, 20'sd100);
      filter_en = 1'b0;
      idle(2);
      filter_en = 1'b1;
      idle(1);
      for (int i = 0; i < 4; i++) step(1'b1, 20'sd8);
      drain();
      check_count("en_drop", base, 1);
      check_val("en_drop_8", base, 20'd8, 1'b0);
   endtask

   task automatic test_reset_mid();
      int base = obs_q.size();
      // Reset while a result is in flight in the output pipeline.
      restart(3'd0, 20'sd0);
      step(1'b1, 20'sd77);
      apply_reset();
      // Reset mid-window: the two earlier samples must not count.
      restart(3'd2, 20'sd0);
      step(1'b1, 20'sd1000); step(1'b1, 20'sd1000);
      apply_reset();
      idle(1);
      step(1'b1, 20'sd40); step(1'b1, 20'sd40);
      idle(3);
      check_count("rst_partial", base, 0);
      step(1'b1, 20'sd80); step(1'b1, 20'sd80);
      drain();
      check_count("rst_full", base, 1);
      check_val("rst_full_60", base, 20'd60, 1'b0);
   endtask

   task automatic test_random();
      for (int chunk = 0; chunk < 8; chunk++) begin
         logic signed [19:0] off;
         off = (chunk % 3 == 0) ? 20'($urandom) : 20'($signed($urandom_range(0, 2000)) - 1000);
         restart(3'($urandom_range(0, 4)), off);
         for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) odr_sel = 3'($urandom_range(0, 4));
            filter_en = ($urandom_range(0, 39) != 0);
            step(1'($urandom), 20'($urandom));
            filter_en = 1'b1;
         end
         drain();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_saturation();
      test_back_to_back();
      test_odr_change();
      test_filter_en_drop();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/accel_decim_filter.md
Name: accel_decim_filter

Overview:
- Upstream stage of the sample FIFO: decimating boxcar averager with offset trim on the raw 20-bit signed ADXL355 axis samples.
- Produces one averaged, offset-corrected, saturated 20-bit sample per window of 2^odr_sel input samples.
- Output is a single-cycle wr_en pulse with filter_fifo_data, matching the FIFO write port directly.

Parameters:
DATA_WIDTH, 20, sample width (signed two's complement) in and out
MAX_DEC_LOG2, 7, largest decimation exponent; window length max 128
ACC_WIDTH, DATA_WIDTH+MAX_DEC_LOG2, accumulator width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
adc_data  in  DATA_WIDTH  signed raw sample
adc_valid  in  1  one-cycle strobe, adc_data valid
filter_en  in  1  enable; low = idle, partial window discarded
odr_sel  in  3  decimation exponent, window N = 2^odr_sel
offset  in  DATA_WIDTH  signed offset subtracted from average
filter_fifo_data  out  DATA_WIDTH  averaged sample to FIFO
wr_en  out  1  one-cycle write strobe to FIFO
overrange  out  1  high with wr_en when result was saturated
Reset is rst_n, asynchronous, active-low; clock is clk.

Behaviour:
- Reset: state IDLE, acc=0, cnt=0, sel_r=0, pend=0, filter_fifo_data=0, wr_en=0, overrange=0. Reset mid-window discards everything; no wr_en after release until a full new window.
- FSM IDLE: filter_en=0, acc/cnt held at 0, adc_valid ignored. IDLE->ACCUM when filter_en=1; sel_r <= min(odr_sel, MAX_DEC_LOG2) on entry.
- ACCUM: each adc_valid: acc <= acc + sign_ext(adc_data), cnt <= cnt+1.
- Window end: adc_valid with cnt == 2^sel_r - 1. Then sum_r <= acc + sample, pend <= 1, acc <= 0, cnt <= 0, sel_r re-samples odr_sel. odr_sel changes mid-window take effect only at the next window.
- Output stage, cycle after pend: avg = sum_r >>> sel_r (arithmetic, floor). res = avg - offset in DATA_WIDTH+1 bits, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Register res into filter_fifo_data; wr_en=1 for exactly one cycle; overrange=1 iff clamped. pend clears.
- Latency: wr_en asserts 2 clk after the clock edge sampling the final adc_valid. filter_fifo_data holds its value until the next wr_en.
- Back-to-back: adc_valid in the cycle after window end is accepted into the fresh window; no sample lost. Minimum adc_valid spacing is 1 cycle. odr_sel=0 gives one output per input.
- filter_en falling in ACCUM: ->IDLE next cycle, partial window discarded. A pending output (pend=1) still completes.
- Accumulator cannot overflow: ACC_WIDTH covers 2^MAX_DEC_LOG2 full-scale samples.
- wr_en is independent of FIFO full; the FIFO handles overwrite.

Decomposition:
- Shared package accel_pkg: DATA_WIDTH, MAX_DEC_LOG2, SAT_MAX = 2^(DATA_WIDTH-1)-1, SAT_MIN = -2^(DATA_WIDTH-1), and the state encoding IDLE/ACCUM.
- One sub-module, accel_sat_sub: combinational saturating subtract (DATA_WIDTH+1 signed minus DATA_WIDTH signed -> DATA_WIDTH result plus clamp flag). Reused by later trim stages.

Test Plan:
- odr_sel=2, offset=0, samples 100, 200, 300, 400 -> single wr_en 2 clk after 4th sample; filter_fifo_data=250, overrange=0.
- odr_sel=1, samples -3, -4 -> -7>>>1 = -4 (0xFFFFC); offset=5 gives -9 (0xFFFF7).
- odr_sel=0, offset=-10, sample 524280 -> saturate 524287 (0x7FFFF), overrange=1. Sample -524288 with offset=1 -> 0x80000, overrange=1.
- odr_sel=2, consecutive adc_valid every cycle for 12 samples 1..12 -> three wr_en pulses with 2, 6, 10 (floor of 2.5, 6.5, 10.5); no dropped sample.
- odr_sel 2->3 after 2nd sample of window -> first window still 4 samples, next window 8 samples. odr_sel=7 with 128×524287 -> 524287, no overflow.
- filter_en low after 3 of 4 samples, then high, then 4 samples of 8 -> one wr_en with 8; no output from the partial window. rst_n pulsed mid-window -> all outputs 0 asynchronously, and the next output requires a full window.
